// File: rtl/ldr_frame_sequencer.sv
// Frame sequencer around a Levinson-Durbin core: collects R0..R10, runs the core
// with a cycle timeout, then streams the A0..A10 coefficients downstream.
module ldr_frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r_valid,
    output logic          r_ready,
    input  logic [15:0]   r_data,
    input  logic          r_last,
    output logic [175:0]  ldr_r,
    output logic          ldr_rst,
    output logic          ldr_start,
    input  logic          ldr_done,
    input  logic [175:0]  ldr_a,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [15:0]   a_data,
    output logic          a_last,
    input  logic          clear_err,
    output logic          err_frame,
    output logic          err_timeout,
    output logic          busy,
    output logic [15:0]   frame_count
);

    // state   | meaning
    // S_LOAD  | accept R0..R10 from the input stream, validate frame shape and R0
    // S_CLEAR | one-cycle reset pulse to the core
    // S_RUN   | hold start to the core, count cycles towards the timeout
    // S_DRAIN | stream A0..A10 downstream, one word per handshake
    typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_RUN, S_DRAIN} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [3:0]          idx;
    logic [10:0][15:0]   r_reg;
    logic [10:0][15:0]   a_reg;
    logic [CW-1:0]       to_cnt;

    logic r_hs;
    logic a_hs;
    logic r0_pos;
    logic idx_end;
    logic frame_err_set;
    logic timeout_set;

    // Handshake-facing outputs are gated by rst so they are quiet during reset itself.
    assign r_ready   = (state == S_LOAD) && !rst;
    assign a_valid   = (state == S_DRAIN) && !rst;
    assign ldr_start = (state == S_RUN) && !rst;
    assign ldr_rst   = rst || (state == S_CLEAR);
    assign busy      = (state != S_LOAD) && !rst;
    assign ldr_r     = r_reg;
    assign a_data    = a_reg[idx];
    assign idx_end   = (idx == 4'd10);
    assign a_last    = a_valid && idx_end;

    assign r_hs   = r_ready && r_valid;
    assign a_hs   = a_valid && a_ready;
    assign r0_pos = $signed(r_reg[0]) > 16'sd0;

    always_comb begin
        frame_err_set = 1'b0;
        if (r_hs) begin
            if (!idx_end && r_last)
                frame_err_set = 1'b1;
            else if (idx_end && (!r_last || !r0_pos))
                frame_err_set = 1'b1;
        end
    end

    // Done takes priority over an expiring timeout in the same cycle.
    assign timeout_set = (state == S_RUN) && !ldr_done && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            idx         <= 4'd0;
            r_reg       <= '0;
            a_reg       <= '0;
            to_cnt      <= '0;
            frame_count <= 16'd0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (r_hs) begin
                        r_reg[idx] <= r_data;
                        if (idx_end) begin
                            idx <= 4'd0;
                            if (r_last && r0_pos)
                                state <= S_CLEAR;
                        end else if (r_last) begin
                            idx <= 4'd0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    to_cnt <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (ldr_done) begin
                        a_reg <= ldr_a;
                        idx   <= 4'd0;
                        state <= S_DRAIN;
                    end else if (timeout_set) begin
                        idx   <= 4'd0;
                        state <= S_LOAD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (a_hs) begin
                        if (idx_end) begin
                            idx         <= 4'd0;
                            frame_count <= frame_count + 16'd1;
                            state       <= S_LOAD;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                    idx   <= 4'd0;
                end
            endcase

            err_frame   <= frame_err_set || (err_frame && !clear_err);
            err_timeout <= timeout_set || (err_timeout && !clear_err);
        end
    end

endmodule

// File: doc/ldr_frame_sequencer.md
LDR_FRAME_SEQUENCER -- requirements
Module: ldr_frame_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum RUN-state cycles before abort.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port r_valid, input, 1: autocorrelation word valid.
REQ-005 SHALL have port r_ready, output, 1: sequencer accepts r_data.
REQ-006 SHALL have port r_data, input, 16: signed word; frame order R0..R10.
REQ-007 SHALL have port r_last, input, 1: marks final word of an input frame.
REQ-008 SHALL have port ldr_r, output, 176: R0..R10 to the LDR core; R0 in [15:0], Rk in [16k+15:16k].
REQ-009 SHALL have port ldr_rst, output, 1: LDR core reset.
REQ-010 SHALL have port ldr_start, output, 1: LDR core start level.
REQ-011 SHALL have port ldr_done, input, 1: LDR core done.
REQ-012 SHALL have port ldr_a, input, 176: A0..A10 from the core, same packing as ldr_r.
REQ-013 SHALL have port a_valid, output, 1: coefficient word valid.
REQ-014 SHALL have port a_ready, input, 1: downstream accepts a_data.
REQ-015 SHALL have port a_data, output, 16: signed coefficient; order A0..A10.
REQ-016 SHALL have port a_last, output, 1: high with A10.
REQ-017 SHALL have port clear_err, input, 1: one-cycle pulse clearing sticky error flags.
REQ-018 SHALL have port err_frame, output, 1: sticky malformed-frame or R0<=0 flag.
REQ-019 SHALL have port err_timeout, output, 1: sticky core-timeout flag.
REQ-020 SHALL have port busy, output, 1: high in any state other than LOAD.
REQ-021 SHALL have port frame_count, output, 16: completed output frames, wraps 0xFFFF->0.

Function
REQ-022 SHALL implement states LOAD, CLEAR, RUN, DRAIN; a 4-bit index counts 0..10.
REQ-023 LOAD SHALL assert r_ready; each r_valid&r_ready cycle SHALL write r_data to R[idx] and increment idx.
REQ-024 In LOAD, r_last with idx<10 SHALL set err_frame, reset idx to 0, and remain in LOAD.
REQ-025 In LOAD, idx==10 with r_last low SHALL set err_frame, reset idx to 0, and remain in LOAD.
REQ-026 In LOAD, idx==10 with r_last high and R0>0 SHALL enter CLEAR; with R0<=0 (signed) it SHALL set err_frame and return idx to 0.
REQ-027 CLEAR SHALL assert ldr_rst for exactly one cycle, then enter RUN.
REQ-028 RUN SHALL hold ldr_start high, deassert ldr_rst, and increment a timeout counter cleared on RUN entry.
REQ-029 In RUN, ldr_done high SHALL capture ldr_a into A[0..10], deassert ldr_start next cycle, and enter DRAIN.
REQ-030 In RUN, counter==TIMEOUT_CYCLES-1 with ldr_done low SHALL set err_timeout and enter LOAD with idx 0, producing no output.
REQ-031 ldr_done and timeout in the same cycle SHALL resolve as done.
REQ-032 ldr_r SHALL reflect R registers continuously; R SHALL not change outside LOAD.
REQ-033 DRAIN SHALL assert a_valid with a_data=A[idx]; a_last=(idx==10); a handshake increments idx.
REQ-034 a_valid and a_data SHALL stay stable until handshake; no a_valid drop without handshake.
REQ-035 The A10 handshake SHALL increment frame_count, reset idx, and enter LOAD the next cycle.
REQ-036 r_ready SHALL be low in CLEAR, RUN, DRAIN; a_valid low outside DRAIN.
REQ-037 clear_err SHALL zero both flags; an error event in the same cycle SHALL win (flag set).
REQ-038 Frame latency: last input handshake -> CLEAR +1 -> RUN +2 -> first a_valid 1 cycle after ldr_done.

Reset
REQ-039 rst SHALL force state LOAD, idx 0, R and A registers 0, counters 0, flags 0.
REQ-040 While rst is high: r_ready=0, a_valid=0, ldr_start=0, ldr_rst=1, busy=0.
REQ-041 rst mid-RUN or mid-DRAIN SHALL abort the frame without output or frame_count change.

Verification
REQ-042 11 words R0=0x7FFF, R1..R10 ramp, r_last on R10, ldr_done model 20 cycles after start -> one ldr_rst pulse, then ldr_start, then A0..A10 out, a_last on A10, frame_count=1.
REQ-043 r_last on 5th word -> err_frame=1, no ldr_rst pulse; next well-formed frame processes normally.
REQ-044 Frame with R0=0xFFFF (-1) -> err_frame=1, no CLEAR; clear_err pulse -> err_frame=0.
REQ-045 TIMEOUT_CYCLES=16, ldr_done never asserted -> err_timeout=1 after 16 RUN cycles, state LOAD, a_valid never high.
REQ-046 a_ready toggled randomly during DRAIN -> a_data stable while stalled, all 11 words delivered in order.
REQ-047 rst pulsed during DRAIN after 3 words -> a_valid=0 immediately, frame_count unchanged, r_ready=1 after release.
